// File: rtl/mlp_acc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : mlp_acc_pkg
// Description : Shared types and default sizing for the MLP load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_acc_pkg;

  localparam int DATA_W         = 32;
  localparam int NUM_IN_ROWS    = 16;
  localparam int NUM_LAYERS_MAX = 8;
  localparam int NUM_WT_BEATS   = 8;
  localparam int RES_PER_LAYER  = 8;

  localparam int ROW_W   = (NUM_IN_ROWS    > 1) ? $clog2(NUM_IN_ROWS)    : 1;
  localparam int LAYER_W = (NUM_LAYERS_MAX > 1) ? $clog2(NUM_LAYERS_MAX) : 1;
  localparam int WT_W    = (NUM_WT_BEATS   > 1) ? $clog2(NUM_WT_BEATS)   : 1;

  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_IN  = 3'd1,
    ST_LOAD_WT  = 3'd2,
    ST_WAIT_RES = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/mlp_load_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : mlp_load_sequencer_if
// Description : Stream input, accelerator load/result and result-FIFO output
//               signals of the load sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface mlp_load_sequencer_if #(
  parameter int DATA_W  = mlp_acc_pkg::DATA_W,
  parameter int ROW_W   = mlp_acc_pkg::ROW_W,
  parameter int LAYER_W = mlp_acc_pkg::LAYER_W,
  parameter int WT_W    = mlp_acc_pkg::WT_W
);
  // word stream in
  logic               s_valid_i;
  logic [DATA_W-1:0]  s_data_i;
  logic               s_ready_o;
  // accelerator load side
  logic               load_en_o;
  logic [DATA_W-1:0]  load_payload_o;
  logic               load_type_o;
  logic [ROW_W-1:0]   input_load_number_o;
  logic [LAYER_W-1:0] layer_number_o;
  logic [WT_W-1:0]    weight_number_o;
  // accelerator results in
  logic               acc_valid_i;
  logic [DATA_W-1:0]  acc_data_i;
  // buffered results out
  logic               m_valid_o;
  logic [DATA_W-1:0]  m_data_o;
  logic               m_ready_i;

  // sequencer side
  modport master (
    input  s_valid_i, s_data_i, acc_valid_i, acc_data_i, m_ready_i,
    output s_ready_o, load_en_o, load_payload_o, load_type_o,
           input_load_number_o, layer_number_o, weight_number_o,
           m_valid_o, m_data_o
  );

  // environment side (stream source, accelerator, result sink)
  modport slave (
    output s_valid_i, s_data_i, acc_valid_i, acc_data_i, m_ready_i,
    input  s_ready_o, load_en_o, load_payload_o, load_type_o,
           input_load_number_o, layer_number_o, weight_number_o,
           m_valid_o, m_data_o
  );
endinterface
`default_nettype wire

// File: rtl/mlp_res_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mlp_res_fifo
// Description : Synchronous result FIFO with flush; head is registered, so a
//               word pushed into an empty FIFO is visible the next cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_res_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // a full FIFO still accepts a word when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = empty ? '0 : mem[rd_ptr];

  // pointer and occupancy tracking; depth is a power of two so pointers wrap
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (do_pop && !do_push) count <= count - (AW+1)'(1);
    end
  end

  // storage array, no reset needed since dout is gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule
`default_nettype wire

// File: rtl/mlp_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mlp_load_sequencer
// Description : Turns a valid/ready word stream into accelerator load beats
//               (input rows, then weights per layer), waits for each layer's
//               results and buffers all results in a FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_load_sequencer #(
  parameter int DATA_W         = 32,
  parameter int NUM_IN_ROWS    = 16,
  parameter int NUM_LAYERS_MAX = 8,
  parameter int NUM_WT_BEATS   = 8,
  parameter int RES_PER_LAYER  = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYC    = 1024,
  localparam int ROW_W   = (NUM_IN_ROWS    > 1) ? $clog2(NUM_IN_ROWS)    : 1,
  localparam int LAYER_W = (NUM_LAYERS_MAX > 1) ? $clog2(NUM_LAYERS_MAX) : 1,
  localparam int WT_W    = (NUM_WT_BEATS   > 1) ? $clog2(NUM_WT_BEATS)   : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [LAYER_W-1:0] last_layer_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_timeout_o,
  output logic               overflow_o,
  mlp_load_sequencer_if.master bus
);
  import mlp_acc_pkg::*;

  localparam int RES_W  = (RES_PER_LAYER > 1) ? $clog2(RES_PER_LAYER) : 1;
  localparam int IDLE_W = (TIMEOUT_CYC   > 1) ? $clog2(TIMEOUT_CYC)   : 1;

  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(NUM_IN_ROWS - 1);
  localparam logic [WT_W-1:0]   WT_LAST   = WT_W'(NUM_WT_BEATS - 1);
  localparam logic [RES_W-1:0]  RES_LAST  = RES_W'(RES_PER_LAYER - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYC - 1);

  seq_state_e         state;
  logic [ROW_W-1:0]   row_cnt;
  logic [WT_W-1:0]    wt_cnt;
  logic [LAYER_W-1:0] layer;
  logic [LAYER_W-1:0] last_layer;
  logic [RES_W-1:0]   res_cnt;
  logic [IDLE_W-1:0]  idle_cnt;
  logic               err_timeout;
  logic               overflow;

  logic               load_en;
  logic               load_type;
  logic [DATA_W-1:0]  load_payload;
  logic [ROW_W-1:0]   row_num;
  logic [WT_W-1:0]    wt_num;

  logic               start_accept;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_drop;

  assign start_accept = (state == ST_IDLE) && start_i && !abort_i;

  // results are captured in every state except IDLE; abort flushes instead
  assign fifo_push = bus.acc_valid_i && (state != ST_IDLE);
  assign fifo_pop  = !fifo_empty && bus.m_ready_i;
  assign fifo_drop = fifo_push && fifo_full && !fifo_pop && !abort_i;

  mlp_res_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort_i),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (bus.acc_data_i),
    .dout  (bus.m_data_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // phase sequencing, beat counters and the registered load outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      row_cnt      <= '0;
      wt_cnt       <= '0;
      layer        <= '0;
      last_layer   <= '0;
      res_cnt      <= '0;
      idle_cnt     <= '0;
      err_timeout  <= 1'b0;
      load_en      <= 1'b0;
      load_type    <= 1'b0;
      load_payload <= '0;
      row_num      <= '0;
      wt_num       <= '0;
    end else begin
      load_en <= 1'b0;
      if (abort_i) begin
        // a handshake in the abort cycle is dropped, not forwarded
        state <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start_i) begin
              state       <= ST_LOAD_IN;
              row_cnt     <= '0;
              wt_cnt      <= '0;
              layer       <= '0;
              res_cnt     <= '0;
              idle_cnt    <= '0;
              last_layer  <= last_layer_i;
              err_timeout <= 1'b0;
            end
          end
          ST_LOAD_IN: begin
            if (bus.s_valid_i) begin
              load_en      <= 1'b1;
              load_type    <= 1'b1;
              load_payload <= bus.s_data_i;
              row_num      <= row_cnt;
              if (row_cnt == ROW_LAST) begin
                state  <= ST_LOAD_WT;
                layer  <= '0;
                wt_cnt <= '0;
              end else begin
                row_cnt <= row_cnt + ROW_W'(1);
              end
            end
          end
          ST_LOAD_WT: begin
            if (bus.s_valid_i) begin
              load_en      <= 1'b1;
              load_type    <= 1'b0;
              load_payload <= bus.s_data_i;
              wt_num       <= wt_cnt;
              if (wt_cnt == WT_LAST) begin
                state    <= ST_WAIT_RES;
                res_cnt  <= '0;
                idle_cnt <= '0;
              end else begin
                wt_cnt <= wt_cnt + WT_W'(1);
              end
            end
          end
          ST_WAIT_RES: begin
            if (bus.acc_valid_i) begin
              idle_cnt <= '0;
              if (res_cnt == RES_LAST) begin
                res_cnt <= '0;
                if (layer == last_layer) begin
                  state <= ST_DONE;
                end else begin
                  layer  <= layer + LAYER_W'(1);
                  wt_cnt <= '0;
                  state  <= ST_LOAD_WT;
                end
              end else begin
                res_cnt <= res_cnt + RES_W'(1);
              end
            end else if (idle_cnt == IDLE_LAST) begin
              err_timeout <= 1'b1;
              state       <= ST_DONE;
            end else begin
              idle_cnt <= idle_cnt + IDLE_W'(1);
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // sticky overflow: set on a dropped result, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (start_accept) begin
      overflow <= 1'b0;
    end else if (fifo_drop) begin
      overflow <= 1'b1;
    end
  end

  assign busy_o        = (state != ST_IDLE);
  assign done_o        = (state == ST_DONE);
  assign err_timeout_o = err_timeout;
  assign overflow_o    = overflow;

  assign bus.s_ready_o           = (state == ST_LOAD_IN) || (state == ST_LOAD_WT);
  assign bus.load_en_o           = load_en;
  assign bus.load_type_o         = load_type;
  assign bus.load_payload_o      = load_payload;
  assign bus.input_load_number_o = row_num;
  assign bus.weight_number_o     = wt_num;
  assign bus.layer_number_o      = layer;
  assign bus.m_valid_o           = !fifo_empty;
endmodule
`default_nettype wire

// File: tb/tb_mlp_load_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_load_sequencer
// Description : Randomised self-checking bench for mlp_load_sequencer with a
//               beat-count based reference model of the job.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_load_sequencer;
  import mlp_acc_pkg::*;

  localparam int ROWS  = 16;
  localparam int WT    = 8;
  localparam int RES   = 8;
  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [LAYER_W-1:0] last_layer = '0;
  logic               busy;
  logic               done;
  logic               err_timeout;
  logic               overflow;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int t_load = 0;
  int t_done = 0;
  int n_ld_in = 0;
  int n_ld_wt = 0;
  int n_done = 0;

  // reference model: job progress in beats/results, FIFO as a queue
  bit    m_act, m_done, m_err, m_ovf;
  int    m_beats, m_lay, m_res, m_idle, m_last;
  word_t q[$];
  bit    e_len, e_type;
  word_t e_pay;
  int    e_row, e_wt;

  mlp_load_sequencer_if bus ();

  mlp_load_sequencer #(
    .DATA_W         (DATA_W),
    .NUM_IN_ROWS    (ROWS),
    .NUM_LAYERS_MAX (NUM_LAYERS_MAX),
    .NUM_WT_BEATS   (WT),
    .RES_PER_LAYER  (RES),
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYC    (TO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start),
    .last_layer_i  (last_layer),
    .abort_i       (abort),
    .busy_o        (busy),
    .done_o        (done),
    .err_timeout_o (err_timeout),
    .overflow_o    (overflow),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit m_loading();
    return m_act && (m_beats < ROWS + WT * (m_lay + 1));
  endfunction

  task automatic model_reset();
    m_act = 0; m_done = 0; m_err = 0; m_ovf = 0;
    m_beats = 0; m_lay = 0; m_res = 0; m_idle = 0; m_last = 0;
    q.delete();
    e_len = 0;
  endtask

  task automatic idle_inputs();
    bus.s_valid_i   = 1'b0;
    bus.s_data_i    = '0;
    bus.acc_valid_i = 1'b0;
    bus.acc_data_i  = '0;
    bus.m_ready_i   = 1'b0;
  endtask

  // one clock: advance the model with the applied inputs, then compare
  task automatic cycle();
    bit ld, hs, pop, push;
    ld = m_loading();
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      hs    = ld && bus.s_valid_i && !abort;
      pop   = (q.size() > 0) && bus.m_ready_i;
      push  = bus.acc_valid_i && (m_act || m_done);
      e_len = 0;
      if (abort) begin
        q.delete();
      end else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          if (q.size() < DEPTH) q.push_back(bus.acc_data_i);
          else m_ovf = 1;
        end
      end
      if (abort) begin
        m_act = 0; m_done = 0;
      end else if (m_done) begin
        m_done = 0;
      end else if (!m_act) begin
        if (start) begin
          m_act = 1; m_beats = 0; m_lay = 0; m_res = 0; m_idle = 0;
          m_err = 0; m_ovf = 0; m_last = int'(last_layer);
        end
      end else if (ld) begin
        if (hs) begin
          e_len = 1;
          e_pay = bus.s_data_i;
          if (m_beats < ROWS) begin
            e_type = 1; e_row = m_beats;
          end else begin
            e_type = 0; e_wt = (m_beats - ROWS) % WT;
          end
          m_beats++;
          if (m_beats == ROWS + WT * (m_lay + 1)) begin
            m_res = 0; m_idle = 0;
          end
        end
      end else begin
        if (bus.acc_valid_i) begin
          m_idle = 0;
          m_res++;
          if (m_res == RES) begin
            m_res = 0;
            if (m_lay == m_last) begin
              m_act = 0; m_done = 1;
            end else begin
              m_lay++;
            end
          end
        end else if (m_idle == TO - 1) begin
          m_err = 1; m_act = 0; m_done = 1;
        end else begin
          m_idle++;
        end
      end
    end
    #1;
    check_val("busy", busy, m_act || m_done);
    check_val("done", done, m_done);
    check_val("s_ready", bus.s_ready_o, m_loading());
    check_val("err_timeout", err_timeout, m_err);
    check_val("overflow", overflow, m_ovf);
    check_val("load_en", bus.load_en_o, e_len);
    check_val("m_valid", bus.m_valid_o, q.size() > 0);
    check_val("layer", bus.layer_number_o, m_lay);
    if (q.size() > 0) check_val("m_data", bus.m_data_o, q[0]);
    if (e_len) begin
      check_val("load_type", bus.load_type_o, e_type);
      check_val("load_payload", bus.load_payload_o, e_pay);
      if (e_type) check_val("row_idx", bus.input_load_number_o, e_row);
      else        check_val("wt_idx", bus.weight_number_o, e_wt);
    end
    if (bus.load_en_o) begin
      t_load = cyc;
      if (bus.load_type_o) n_ld_in++;
      else                 n_ld_wt++;
    end
    if (done) begin
      t_done = cyc;
      n_done++;
    end
  endtask

  task automatic start_job(input int lay);
    idle_inputs();
    last_layer = LAYER_W'(lay);
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // vmode: 0 full rate, 1 toggling, 2 random; probabilities in percent
  task automatic drive(input int vmode, input int aprob, input int lprob,
                       input int rprob, input int sprob, input int budget,
                       input int stop_at);
    int i;
    i = 0;
    while (i < budget && (m_act || m_done) && m_beats != stop_at) begin
      case (vmode)
        0:       bus.s_valid_i = 1'b1;
        1:       bus.s_valid_i = (i % 2 == 0);
        default: bus.s_valid_i = ($urandom_range(99) < 70);
      endcase
      bus.s_data_i = $urandom;
      if (m_act && !m_loading()) bus.acc_valid_i = ($urandom_range(99) < aprob);
      else                       bus.acc_valid_i = ($urandom_range(99) < lprob);
      bus.acc_data_i = $urandom;
      bus.m_ready_i  = ($urandom_range(99) < rprob);
      start          = ($urandom_range(99) < sprob);
      cycle();
      i++;
    end
    start = 1'b0;
    idle_inputs();
    if (stop_at < 0) check_val("job_end_busy", busy, 0);
  endtask

  task automatic drain(input int n);
    idle_inputs();
    bus.m_ready_i = 1'b1;
    for (int i = 0; i < n; i++) cycle();
    bus.m_ready_i = 1'b0;
  endtask

  initial begin
    int popped;
    model_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
    check_val("rst_busy", busy, 0);
    check_val("rst_load_en", bus.load_en_o, 0);
    check_val("rst_m_valid", bus.m_valid_o, 0);

    // 1: two layers at full rate
    n_ld_in = 0; n_ld_wt = 0; n_done = 0;
    start_job(1);
    drive(0, 100, 0, 100, 0, 500, -1);
    check_val("t1_in_loads", n_ld_in, ROWS);
    check_val("t1_wt_loads", n_ld_wt, 2 * WT);
    check_val("t1_done_pulses", n_done, 1);

    // 2: toggling stream valid
    n_ld_in = 0; n_ld_wt = 0; n_done = 0;
    start_job(1);
    drive(1, 50, 0, 100, 0, 1000, -1);
    check_val("t2_in_loads", n_ld_in, ROWS);
    check_val("t2_wt_loads", n_ld_wt, 2 * WT);
    check_val("t2_done_pulses", n_done, 1);
    drain(DEPTH + 2);

    // 3: results with the sink stalled overflow the FIFO
    start_job(0);
    drive(0, 100, 0, 0, 0, 500, -1);
    check_val("t3_overflow", overflow, 1);
    popped = 0;
    bus.m_ready_i = 1'b1;
    for (int i = 0; i < DEPTH + 2; i++) begin
      if (bus.m_valid_o) popped++;
      cycle();
    end
    bus.m_ready_i = 1'b0;
    check_val("t3_popped", popped, DEPTH);

    // 4: no results -> timeout
    start_job(0);
    drive(0, 0, 0, 100, 0, 500, -1);
    check_val("t4_done_latency", t_done - t_load, TO);
    check_val("t4_err_timeout", err_timeout, 1);

    // 5: abort at row 7 with results buffered, then a clean restart
    start_job(1);
    drive(0, 100, 50, 0, 0, 500, 7);
    bus.s_valid_i = 1'b1;
    bus.s_data_i  = $urandom;
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    idle_inputs();
    check_val("t5_s_ready", bus.s_ready_o, 0);
    check_val("t5_m_valid", bus.m_valid_o, 0);
    check_val("t5_busy", busy, 0);
    check_val("t5_load_en", bus.load_en_o, 0);
    start_job(1);
    drive(0, 100, 0, 100, 0, 500, -1);

    // 6: start while busy, then reset in the middle of the weight phase
    start_job(2);
    drive(2, 80, 10, 60, 30, 2000, ROWS + 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_val("t6_busy", busy, 0);
    check_val("t6_done", done, 0);
    check_val("t6_err", err_timeout, 0);
    check_val("t6_ovf", overflow, 0);
    check_val("t6_s_ready", bus.s_ready_o, 0);
    check_val("t6_load_en", bus.load_en_o, 0);
    check_val("t6_load_type", bus.load_type_o, 0);
    check_val("t6_payload", bus.load_payload_o, 0);
    check_val("t6_row", bus.input_load_number_o, 0);
    check_val("t6_wt", bus.weight_number_o, 0);
    check_val("t6_layer", bus.layer_number_o, 0);
    check_val("t6_m_valid", bus.m_valid_o, 0);
    check_val("t6_m_data", bus.m_data_o, 0);

    // random jobs
    for (int j = 0; j < 4; j++) begin
      start_job($urandom_range(0, 3));
      drive(2, 60, 10, 70, 10, 4000, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
